adrv9009_tx_tone_gen: RTL
=========================

Name: adrv9009_tx_tone_gen

Overview:
Transmit-side stimulus source for the ADRV9009 TX signal path. It produces an 8-phase quantized sine: 0, 23170, 32767, 23170, 0, -23170, -32768, -23170. Each phase is held for a programmable number of samples. The output has a valid/ready handshake, plus per-phase attenuation and inversion. It sits ahead of the TX datapath and is the transmit counterpart of the receiver signal path stimulus.

Parameters:
HOLD, 9, samples per phase minus one (each phase emits HOLD+1 accepted samples); legal range 0..255.
DW, 16, output sample width (signed, two's complement); fixed at 16 for this table.

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
enable  in  1  level; start/continue tone generation
gain_shift  in  2  arithmetic right-shift attenuation, 0..3
invert  in  1  negate sample (with saturation)
out_ready  in  1  downstream accepts sample
out_valid  out  1  out_data holds a valid sample
out_data  out  16  signed tone sample
phase  out  3  current table index 0..7
cycle_done  out  1  one-cycle pulse on acceptance of the last sample of phase 7

Behaviour:
- Reset (async, active-high) forces: state=IDLE, out_valid=0, out_data=0, phase=0, hold counter=0, cycle_done=0. This applies at any time, including mid-tone.
- Handshake: a sample is accepted on a rising clk edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data and phase must not change.
  - out_valid never drops without an acceptance, except on reset.
- State machine: IDLE, RUN, STOP.
  - IDLE: out_valid=0. If enable=1 → RUN; on that edge load out_data = scaled table[0] and set out_valid=1. Latency is 1 cycle from enable sampled high to the first valid sample.
  - RUN: on each acceptance, hold counter increments. When the counter equals HOLD, it clears and phase advances (7 wraps to 0).
    - If enable=0 is sampled at an edge → STOP, with no loss or repeat of samples.
  - STOP: behaves exactly like RUN, so the current period finishes. On acceptance of the final sample of phase 7 → IDLE, out_valid=0 on that edge, phase=0.
    - If enable returns to 1 while in STOP → RUN with no gap or glitch in the sequence.
- Output register: the next sample is loaded on every acceptance. Its value is scaled table[next phase]. This means gain_shift and invert are sampled at each sample load, not mid-hold.
- Scaling:
  - s = table >>> gain_shift (sign-preserving; -32768 >>> 1 = -16384).
  - If invert=1: out = -s, saturated to [-32768, 32767]. Only -32768 saturates, giving 32767.
- cycle_done: pulse on the edge where the final sample of phase 7 is accepted. This applies in both RUN and STOP.
- HOLD=0: phase advances on every acceptance.
- Simultaneous enable fall and period end: if enable=0 is sampled on the same edge as the final phase-7 acceptance, go directly to IDLE.

Decomposition:
- Shared package holds:
  - sine table constants (SIN_P0..SIN_P7 as 16-bit signed)
  - state encodings IDLE/RUN/STOP
  - saturation limits (DW_MAX = 32767, DW_MIN = -32768)
- One sub-module, adrv9009_tx_tone_scale: a registered shift plus saturating negate, with 1-cycle load timing driven by a load strobe from the FSM.
- The top level holds the FSM, hold counter, phase counter and handshake.

Test Plan:
1. Reset held with enable=0, then released → out_valid=0, out_data=0, phase=0, cycle_done=0 for 20 cycles.
2. HOLD=9, gain_shift=0, invert=0, out_ready=1, enable=1 → output is 10×0, 10×23170, 10×32767, 10×23170, 10×0, 10×-23170, 10×-32768, 10×-23170. cycle_done pulses once after accepted sample 80, then the sequence repeats with no gap.
3. Backpressure: out_ready=0 for 5 cycles during phase 2 → out_data stays at 32767 and out_valid stays 1. Exactly 10 samples of 32767 are accepted and phase is unchanged while stalled.
4. Scaling:
   - gain_shift=2, invert=1 → phase 2 gives -8191 (32767>>>2=8191, negated); phase 6 gives 8192.
   - gain_shift=0, invert=1 → phase 6 gives 32767 (saturated); phase 5 gives 23170.
5. Stop/restart:
   - enable drops during phase 3 → phases 3–7 complete, cycle_done pulses, out_valid=0 on the next edge, phase=0.
   - Second run: enable is re-raised during STOP phase 5 → the sequence continues uninterrupted.
6. Async reset asserted mid phase 5 between clock edges → out_valid and out_data clear immediately. After release with enable=1, output restarts at phase 0 with value 0.

Source files
------------

// File: rtl/adrv9009_tx_tone_gen_pkg.sv
// adrv9009_tx_tone_gen_pkg: shared sine table, FSM encoding and sample scaling helpers
// Revision: 1.0
`default_nettype none

package adrv9009_tx_tone_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic signed [15:0] SIN_P0 = 16'sd0;
   localparam logic signed [15:0] SIN_P1 = 16'sd23170;
   localparam logic signed [15:0] SIN_P2 = 16'sd32767;
   localparam logic signed [15:0] SIN_P3 = 16'sd23170;
   localparam logic signed [15:0] SIN_P4 = 16'sd0;
   localparam logic signed [15:0] SIN_P5 = -16'sd23170;
   localparam logic signed [15:0] SIN_P6 = 16'sh8000;
   localparam logic signed [15:0] SIN_P7 = -16'sd23170;

   localparam logic signed [15:0] DW_MAX = 16'sh7FFF;
   localparam logic signed [15:0] DW_MIN = 16'sh8000;

   function automatic logic signed [15:0] sine_lut(input logic [2:0] idx);
      logic signed [15:0] v;
      case (idx)
         3'd0:    v = SIN_P0;
         3'd1:    v = SIN_P1;
         3'd2:    v = SIN_P2;
         3'd3:    v = SIN_P3;
         3'd4:    v = SIN_P4;
         3'd5:    v = SIN_P5;
         3'd6:    v = SIN_P6;
         default: v = SIN_P7;
      endcase
      return v;
   endfunction

   // Only the most negative code has no positive twin, so it alone clips on negation.
   function automatic logic signed [15:0] scale_sample(input logic signed [15:0] raw,
                                                       input logic [1:0]          shift,
                                                       input logic                inv);
      logic signed [15:0] s;
      s = raw >>> shift;
      if (!inv)
         return s;
      if (s == DW_MIN)
         return DW_MAX;
      return -s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adrv9009_tx_tone_gen_if.sv
// adrv9009_tx_tone_gen_if: sample stream with valid/ready handshake and tone status
// Revision: 1.0
`default_nettype none

interface adrv9009_tx_tone_gen_if #(
   parameter int DW = 16
) ();
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_data;
   logic [2:0]           phase;
   logic                 cycle_done;

   modport master (
      output out_valid,
      output out_data,
      output phase,
      output cycle_done,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  phase,
      input  cycle_done,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/adrv9009_tx_tone_scale.sv
// adrv9009_tx_tone_scale: registered table lookup, attenuation and saturating inversion
// Revision: 1.0
`default_nettype none

module adrv9009_tx_tone_scale
   import adrv9009_tx_tone_gen_pkg::*;
(
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               load,
   input  wire logic [2:0]         sel,
   input  wire logic [1:0]         gain_shift,
   input  wire logic               invert,
   output      logic signed [15:0] sample
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sample <= '0;
      else if (load)
         sample <= scale_sample(sine_lut(sel), gain_shift, invert);
   end

endmodule

`default_nettype wire

// File: rtl/adrv9009_tx_tone_gen.sv
// adrv9009_tx_tone_gen: 8-phase quantized sine source with hold, handshake and stop-at-period-end
// Revision: 1.0
`default_nettype none

module adrv9009_tx_tone_gen
   import adrv9009_tx_tone_gen_pkg::*;
#(
   parameter int HOLD = 9,
   parameter int DW   = 16
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               enable,
   input  wire logic [1:0]         gain_shift,
   input  wire logic               invert,
   adrv9009_tx_tone_gen_if.master  tx
);

   localparam logic [7:0] HOLD_L = 8'(HOLD);

   state_t               state;
   logic [7:0]           hold_cnt;
   logic [2:0]           phase_idx;
   logic                 valid;
   logic                 done;
   logic signed [DW-1:0] sample;

   logic                 accept;
   logic                 last_hold;
   logic                 period_end;
   logic                 start;
   logic                 load;
   logic [2:0]           next_idx;

   always_comb begin
      accept     = valid & tx.out_ready;
      last_hold  = (hold_cnt == HOLD_L);
      period_end = accept & last_hold & (phase_idx == 3'd7);
      start      = (state == IDLE) & enable;
      load       = start | accept;
      next_idx   = 3'd0;
      if (state != IDLE)
         next_idx = last_hold ? 3'(phase_idx + 3'd1) : phase_idx;
   end

   // STOP differs from RUN only in that a period end with enable low returns to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         valid     <= 1'b0;
         phase_idx <= 3'd0;
         hold_cnt  <= 8'd0;
         done      <= 1'b0;
      end else begin
         done <= period_end;
         case (state)
            IDLE: begin
               if (enable) begin
                  state     <= RUN;
                  valid     <= 1'b1;
                  phase_idx <= 3'd0;
                  hold_cnt  <= 8'd0;
               end
            end
            RUN, STOP: begin
               if (accept) begin
                  if (last_hold) begin
                     hold_cnt  <= 8'd0;
                     phase_idx <= 3'(phase_idx + 3'd1);
                  end else begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end
               if (period_end && !enable) begin
                  state     <= IDLE;
                  valid     <= 1'b0;
                  phase_idx <= 3'd0;
               end else begin
                  state <= enable ? RUN : STOP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   adrv9009_tx_tone_scale u_scale (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .sel        (next_idx),
      .gain_shift (gain_shift),
      .invert     (invert),
      .sample     (sample)
   );

   assign tx.out_valid  = valid;
   assign tx.out_data   = sample;
   assign tx.phase      = phase_idx;
   assign tx.cycle_done = done;

endmodule

`default_nettype wire
